// File: rtl/ysyx_23060201_sram_slave_pkg.sv
// Shared constants, FSM state encoding and the address-window helper for the
// SRAM bus responder.
package ysyx_23060201_sram_slave_pkg;

    localparam logic [31:0] MBASE_DEFAULT = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam int unsigned LAT_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;

    // Unsigned 32-bit window test; the subtraction only matters once addr >= base.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] span_bytes);
        return (addr >= base) && ((addr - base) < span_bytes);
    endfunction

endpackage

// File: rtl/ysyx_23060201_sram_array.sv
// Word-organised storage: asynchronous read port, synchronous byte-enabled write
// port. Contents are deliberately not reset so they survive a bus reset.
module ysyx_23060201_sram_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_23060201_sram_slave.sv
// Valid/ready memory responder: one read or write in flight, answered after a
// programmable latency, SLVERR outside the [MBASE, MBASE+4*DEPTH_WORDS) window.
module ysyx_23060201_sram_slave
    import ysyx_23060201_sram_slave_pkg::*;
#(
    parameter logic [31:0] MBASE       = MBASE_DEFAULT,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int             IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [31:0]    SPAN        = 32'(4 * DEPTH_WORDS);
    localparam logic [LAT_W-1:0] RD_CNT_INIT = LAT_W'(RD_LAT - 1);
    localparam logic [LAT_W-1:0] WR_CNT_INIT = LAT_W'(WR_LAT - 1);

    state_t           state, state_next;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_next;
    logic [IDX_W-1:0] idx_q, idx_next;
    logic             addr_ok_q, addr_ok_next;
    logic [31:0]      rdata_next;
    logic [1:0]       rresp_next, bresp_next;
    logic             ar_ok, aw_ok;
    logic [IDX_W-1:0] mem_raddr;
    logic [31:0]      mem_rdata;
    logic             mem_we;

    assign ar_ok = addr_in_range(araddr, MBASE, SPAN);
    assign aw_ok = addr_in_range(awaddr, MBASE, SPAN);

    // In IDLE the array is addressed straight from araddr so a 1-cycle read can capture it.
    assign mem_raddr = (state == IDLE) ? IDX_W'((araddr - MBASE) >> 2) : idx_q;
    assign mem_we    = awready & aw_ok;

    ysyx_23060201_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (IDX_W'((awaddr - MBASE) >> 2)),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            idx_q     <= '0;
            addr_ok_q <= 1'b0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
            bresp     <= RESP_OKAY;
        end else begin
            state     <= state_next;
            lat_cnt   <= lat_cnt_next;
            idx_q     <= idx_next;
            addr_ok_q <= addr_ok_next;
            rdata     <= rdata_next;
            rresp     <= rresp_next;
            bresp     <= bresp_next;
        end
    end

    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        idx_next     = idx_q;
        addr_ok_next = addr_ok_q;
        rdata_next   = rdata;
        rresp_next   = rresp;
        bresp_next   = bresp;
        arready      = 1'b0;
        awready      = 1'b0;
        wready       = 1'b0;
        rvalid       = 1'b0;
        bvalid       = 1'b0;

        unique case (state)
            IDLE: begin
                arready = rst;
                awready = rst & awvalid & wvalid & ~arvalid;
                wready  = awready;
                if (arvalid && arready) begin
                    idx_next     = IDX_W'((araddr - MBASE) >> 2);
                    addr_ok_next = ar_ok;
                    lat_cnt_next = RD_CNT_INIT;
                    if (RD_LAT == 1) begin
                        state_next = RD_RESP;
                        rdata_next = ar_ok ? mem_rdata : '0;
                        rresp_next = ar_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end else if (awready) begin
                    lat_cnt_next = WR_CNT_INIT;
                    bresp_next   = aw_ok ? RESP_OKAY : RESP_SLVERR;
                    state_next   = (WR_LAT == 1) ? WR_RESP : WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt <= LAT_W'(1)) begin
                    lat_cnt_next = '0;
                    state_next   = RD_RESP;
                    rdata_next   = addr_ok_q ? mem_rdata : '0;
                    rresp_next   = addr_ok_q ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    lat_cnt_next = lat_cnt - LAT_W'(1);
                end
            end
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    state_next = IDLE;
                end
            end
            WR_WAIT: begin
                if (lat_cnt <= LAT_W'(1)) begin
                    lat_cnt_next = '0;
                    state_next   = WR_RESP;
                end else begin
                    lat_cnt_next = lat_cnt - LAT_W'(1);
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
